// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the load/store port.
// One transaction in flight; a new accept may overlap the previous response cycle.
module mem_arbiter #(
    parameter int RAM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam logic [2:0] LAT_LAST   = 3'(RAM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    owner_t     owner, owner_next;
    logic [2:0] lat_cnt, lat_cnt_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       wr_flag, wr_flag_next;
    logic       response;
    logic       can_accept;
    logic       grant_inst;
    logic       grant_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_NONE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            wr_flag    <= 1'b0;
        end else begin
            owner      <= owner_next;
            lat_cnt    <= lat_cnt_next;
            starve_cnt <= starve_cnt_next;
            wr_flag    <= wr_flag_next;
        end
    end

    always_comb begin
        owner_next      = owner;
        lat_cnt_next    = lat_cnt;
        starve_cnt_next = starve_cnt;
        wr_flag_next    = wr_flag;

        // Gating with reset keeps every combinational output quiet while reset is held.
        response   = (owner != OWN_NONE) && (lat_cnt == LAT_LAST);
        can_accept = reset && ((owner == OWN_NONE) || response);
        grant_data = can_accept && data_req && !(inst_req && (starve_cnt == STARVE_MAX));
        grant_inst = can_accept && inst_req && !grant_data;

        if (grant_inst || grant_data) begin
            owner_next   = grant_data ? OWN_DATA : OWN_INST;
            lat_cnt_next = 3'd1;
            wr_flag_next = grant_data && data_wr;
        end else if (response) begin
            owner_next   = OWN_NONE;
            lat_cnt_next = 3'd0;
            wr_flag_next = 1'b0;
        end else if (owner != OWN_NONE) begin
            lat_cnt_next = lat_cnt + 3'd1;
        end

        // Counts data wins that kept a waiting fetch out; any fetch-free opportunity resets it.
        if (can_accept) begin
            if (grant_inst || !inst_req) begin
                starve_cnt_next = 4'd0;
            end else if (grant_data && (starve_cnt != STARVE_MAX)) begin
                starve_cnt_next = starve_cnt + 4'd1;
            end
        end

        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        ram_en       = grant_inst || grant_data;
        ram_wen      = (grant_data && data_wr) ? data_wstrb : 4'h0;
        ram_addr     = grant_data ? data_addr : (grant_inst ? inst_addr : 32'h0);
        ram_wdata    = grant_data ? data_wdata : 32'h0;

        inst_data_ok = reset && response && (owner == OWN_INST);
        data_data_ok = reset && response && (owner == OWN_DATA);
        inst_rdata   = inst_data_ok ? ram_rdata : 32'h0;
        data_rdata   = (data_data_ok && !wr_flag) ? ram_rdata : 32'h0;
    end

endmodule
